instr_fetch_ir: RTL
===================

Name: instr_fetch_ir

Overview:
- Fetch sequencer and instruction register for the multi-cycle processor. Sits directly upstream of the immediate extend unit.
- Reads one 16-bit instruction as two bytes from byte-wide instruction memory, with a variable-latency ack handshake.
- Commits the full word atomically into the IR and drives the extend unit's 8-bit immediate and 2-bit length select from the IR fields.
- The control unit requests fetches and loads branch targets into the PC.

Parameters:
- RESET_PC, 8'h00, PC value after reset.
- TIMEOUT, 15, maximum cycles to wait for mem_ack per byte before aborting.
- TO_W, 4, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_req  in  1  control unit requests the next instruction.
- pc_load  in  1  load pc_load_val into the PC (branch/jump).
- pc_load_val  in  8  branch target byte address.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  8  byte address, equal to the PC.
- mem_rdata  in  8  read data, valid when mem_ack=1.
- mem_ack  in  1  memory acknowledge; one-cycle pulse with data.
- busy  out  1  high in FETCH_HI and FETCH_LO.
- instr_valid  out  1  one-cycle pulse when a new IR value is committed.
- fetch_err  out  1  one-cycle pulse on timeout abort.
- pc  out  8  current program counter.
- ir  out  16  instruction register.
- opcode  out  4  ir[15:12].
- len_sel  out  2  ir[11:10], feeds the extend unit's len_sel.
- imm  out  8  ir[7:0], feeds the extend unit's in.

Behaviour:
- Reset (synchronous): pc=RESET_PC, ir=0, hi_buf=0, to_cnt=0, state=IDLE, and mem_rd, busy, instr_valid, fetch_err all 0.
  - Reset asserted mid-fetch aborts the fetch immediately.
  - PC returns to RESET_PC; IR is cleared.
- States: IDLE, FETCH_HI, FETCH_LO, DONE. All outputs are registered or decoded from state.
- IDLE:
  - If pc_load=1, pc <= pc_load_val.
  - If fetch_req=1, go to FETCH_HI.
  - If both are asserted in the same cycle, the load is applied first and the fetch uses the loaded address.
- FETCH_HI:
  - mem_rd=1, mem_addr=pc, busy=1.
  - On mem_ack: hi_buf <= mem_rdata, pc <= pc+1, to_cnt <= 0, go to FETCH_LO.
  - Otherwise to_cnt increments.
- FETCH_LO:
  - Same strobe behaviour as FETCH_HI.
  - On mem_ack: ir <= {hi_buf, mem_rdata}, pc <= pc+1, go to DONE.
- DONE: instr_valid=1 for exactly one cycle, then go to IDLE.
  - A fetch_req seen in DONE is ignored; the control unit re-requests from IDLE.
- IR commit is atomic:
  - ir, opcode, len_sel and imm change only on the FETCH_LO ack edge.
  - They hold stable otherwise, so the extend output never sees a half-updated word.
- Timeout:
  - If to_cnt reaches TIMEOUT without mem_ack in either fetch state, fetch_err pulses one cycle and the FSM returns to IDLE.
  - pc is restored to the address of the instruction's first byte; ir is unchanged.
- pc_load or fetch_req while busy is ignored.
- A mem_ack outside the fetch states is ignored.
- PC arithmetic is modulo 256: 8'hFF+1 = 8'h00. An instruction may straddle the wrap (hi byte at FF, lo byte at 00).
- Minimum latency: fetch_req sampled at edge N, ack held high, gives instr_valid high during the cycle after edge N+3.

Decomposition:
- Shared package holds:
  - State encodings: IDLE=2'd0, FETCH_HI=2'd1, FETCH_LO=2'd2, DONE=2'd3.
  - Instruction field positions: OPC_MSB/LSB=15/12, LEN_MSB/LSB=11/10, IMM_MSB/LSB=7/0.
  - Shared with the control unit and the extend unit.
- One natural sub-module: pc_reg. It is an 8-bit register with synchronous reset to RESET_PC, load, increment and restore inputs, plus priority logic. The FSM and IR live in the top module.

Test Plan:
- Reset, then fetch_req with memory[00]=8'h5A, memory[01]=8'h83, ack on the same cycle as rd -> instr_valid one cycle later than minimum latency predicts is a fail. Required: ir=16'h5A83, opcode=4'h5, len_sel=2'b10, imm=8'h83, pc=8'h02.
- pc_load=1 with pc_load_val=8'h40 and fetch_req=1 in the same IDLE cycle -> mem_addr=8'h40 then 8'h41, and final pc=8'h42.
- Ack delayed 5 cycles per byte -> ir holds its previous value until the FETCH_LO ack edge, and instr_valid is a single pulse.
- No ack for TIMEOUT cycles on the lo byte starting from pc=8'h10 -> fetch_err single pulse, pc=8'h10, ir unchanged, FSM in IDLE.
- pc=8'hFF, memory[FF]=8'h12, memory[00]=8'h34 -> ir=16'h1234 and pc=8'h01.
- Reset asserted while in FETCH_LO -> next cycle state=IDLE, pc=RESET_PC, ir=0, mem_rd=0, no instr_valid pulse.

Source files
------------

// File: rtl/instr_fetch_ir_pkg.sv
// Shared definitions for the fetch sequencer, control unit and immediate extend unit.
package instr_fetch_ir_pkg;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned INSTR_W = 16;

  // Instruction field positions
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 12;
  localparam int unsigned LEN_MSB = 11;
  localparam int unsigned LEN_LSB = 10;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_HI = 2'd1,
    FETCH_LO = 2'd2,
    DONE     = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ir_if.sv
// Byte-wide instruction memory read port with a single-cycle ack.
interface instr_fetch_ir_if;
  import instr_fetch_ir_pkg::*;

  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (output mem_rd, output mem_addr, input mem_rdata, input mem_ack);
  modport slave  (input mem_rd, input mem_addr, output mem_rdata, output mem_ack);
endinterface

// File: rtl/instr_fetch_ir_pc_reg.sv
// Program counter: restore beats load beats increment.
module instr_fetch_ir_pc_reg
  import instr_fetch_ir_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restore,
  input  logic [ADDR_W-1:0] restore_val,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (restore) begin
      pc <= restore_val;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_ir.sv
// Two-byte instruction fetch sequencer with an atomically committed instruction register.
module instr_fetch_ir
  import instr_fetch_ir_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter int unsigned       TIMEOUT  = 15,
  parameter int unsigned       TO_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_req,
  input  logic                       pc_load,
  input  logic [ADDR_W-1:0]          pc_load_val,
  instr_fetch_ir_if.master           mem,
  output logic                       busy,
  output logic                       instr_valid,
  output logic                       fetch_err,
  output logic [ADDR_W-1:0]          pc,
  output logic [INSTR_W-1:0]         ir,
  output logic [OPC_MSB-OPC_LSB:0]   opcode,
  output logic [LEN_MSB-LEN_LSB:0]   len_sel,
  output logic [IMM_MSB-IMM_LSB:0]   imm
);

  fetch_state_e      state, state_next;
  logic [BYTE_W-1:0] hi_buf;
  logic [TO_W-1:0]   to_cnt;
  logic [ADDR_W-1:0] start_pc;
  logic              timeout_hit;

  logic pc_ld, pc_inc, pc_rst;
  logic hi_ld, ir_ld, to_clr, to_inc, err_set, start_ld;

  assign timeout_hit = (to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (fetch_req) state_next = FETCH_HI;
      FETCH_HI: if (mem.mem_ack) state_next = FETCH_LO;
                else if (timeout_hit) state_next = IDLE;
      FETCH_LO: if (mem.mem_ack) state_next = DONE;
                else if (timeout_hit) state_next = IDLE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Strobes and datapath enables decoded from the current state
  always_comb begin
    mem.mem_rd = 1'b0;
    busy       = 1'b0;
    pc_ld      = 1'b0;
    pc_inc     = 1'b0;
    pc_rst     = 1'b0;
    hi_ld      = 1'b0;
    ir_ld      = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    err_set    = 1'b0;
    start_ld   = 1'b0;
    case (state)
      IDLE: begin
        pc_ld    = pc_load;
        start_ld = fetch_req;
        to_clr   = 1'b1;
      end
      FETCH_HI, FETCH_LO: begin
        mem.mem_rd = 1'b1;
        busy       = 1'b1;
        if (mem.mem_ack) begin
          pc_inc = 1'b1;
          to_clr = 1'b1;
          hi_ld  = (state == FETCH_HI);
          ir_ld  = (state == FETCH_LO);
        end else if (timeout_hit) begin
          pc_rst  = 1'b1;
          err_set = 1'b1;
          to_clr  = 1'b1;
        end else begin
          to_inc = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir          <= '0;
      hi_buf      <= '0;
      to_cnt      <= '0;
      start_pc    <= RESET_PC;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      instr_valid <= (state == DONE);
      fetch_err   <= err_set;
      if (hi_ld) hi_buf <= mem.mem_rdata;
      if (ir_ld) ir <= {hi_buf, mem.mem_rdata};
      if (to_clr)      to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
      // Remember the first-byte address so a timeout can rewind the PC
      if (start_ld) start_pc <= pc_load ? pc_load_val : pc;
    end
  end

  instr_fetch_ir_pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk         (clk),
    .reset       (reset),
    .restore     (pc_rst),
    .restore_val (start_pc),
    .load        (pc_ld),
    .load_val    (pc_load_val),
    .inc         (pc_inc),
    .pc          (pc)
  );

  assign mem.mem_addr = pc;
  assign opcode       = ir[OPC_MSB:OPC_LSB];
  assign len_sel      = ir[LEN_MSB:LEN_LSB];
  assign imm          = ir[IMM_MSB:IMM_LSB];

endmodule
